// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and defaults for pipeline-stage skid registers
package pipe_pkg;

    // Default width of the stall-cycle performance counter
    localparam int PIPE_CNT_W = 16;

    // Stage control state, encoded directly as {skid_valid, main_valid}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } pipe_state_t;

    // Execute -> memory payload bundle
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_out;
        logic [31:0] store_data;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } ex_mem_t;

    // Memory -> writeback payload bundle
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_we;
    } mem_wb_t;

    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    // Entry count held in a given state
    function automatic logic [1:0] pipe_occupancy(input pipe_state_t st);
        logic [1:0] bits;
        bits = st;
        return {1'b0, bits[0]} + {1'b0, bits[1]};
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid pipeline register with stall, flush and stall counter
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int                CNT_W   = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       state;
    pipe_state_t       state_nxt;
    logic [1:0]        state_bits;
    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              acc;
    logic              go;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic              stall_cycle;

    assign state_bits = state;
    assign main_valid = state_bits[0];
    assign skid_valid = state_bits[1];

    // in_ready comes straight from the skid flop, so downstream backpressure
    // never reaches the previous stage combinationally
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = pipe_occupancy(state);

    assign acc = in_valid & in_ready;
    assign go  = out_valid & out_ready & ~stall;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and register-load selection; flush overrides any transfer
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_nxt    = BUSY;
                        load_main_in = 1'b1;
                    end
                end
                BUSY: begin
                    if (acc && go) begin
                        load_main_in = 1'b1;
                    end else if (acc) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (go) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (go) begin
                        state_nxt      = BUSY;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Payload registers; main returns to RST_VAL on flush, otherwise only loads on a selected move
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data <= RST_VAL;
            skid_data <= RST_VAL;
        end else if (flush) begin
            main_data <= RST_VAL;
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

    assign stall_cycle = out_valid & ~(out_ready & ~stall);

    // Saturating count of cycles where a valid head entry was not taken; flush leaves it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_cycle && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
